// File: rtl/usb_tx_pkg.sv
// Shared types and helpers for the USB transmit hex formatter: FSM encoding,
// ASCII terminator constants and the nibble-to-ASCII map.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_STROBE,
    ST_RELEASE,
    ST_GAP
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h41 + ({4'h0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Synchronous word FIFO with extra-MSB pointers; writes are refused when full
// and reads when empty, independent of what the other side does that cycle.
module usb_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/usb_tx_hex_formatter.sv
// Renders FIFO-buffered 32-bit words as uppercase ASCII hex bytes for the USB
// serial wrapper's strobe protocol. Define USB_TX_CRLF_EN to append CR LF.
//
// state     | meaning
// IDLE      | waiting for a word in the FIFO
// LOAD      | present the current character on usb_tx_data
// WAIT_DONE | wait for the wrapper to report idle
// STROBE    | enable high for ENABLE_CYCLES
// RELEASE   | enable low, wait out synchronizer latency and done_s
// GAP       | enforced idle time before the next byte
module usb_tx_hex_formatter
  import usb_tx_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ENABLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 16
) (
  input  logic        clk_16mhz,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  usb_tx_data,
  output logic        usb_tx_enable,
  input  logic        usb_tx_done,
  output logic        busy
);

`ifdef USB_TX_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif
  localparam logic [1:0] STROBE_LOAD  = 2'(ENABLE_CYCLES - 1);
  localparam logic [1:0] RELEASE_LOAD = 2'd2;
  localparam logic [7:0] GAP_LOAD     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        enable_q, enable_d;
  logic        done_meta_q, done_s_q;
  logic [7:0]  cur_char;

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] fifo_rdata;

  usb_tx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_16mhz),
    .reset_i (reset),
    .push_i  (in_valid && in_ready),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready      = !fifo_full;
  assign busy          = !fifo_empty || (state_q != ST_IDLE);
  assign usb_tx_data   = data_q;
  assign usb_tx_enable = enable_q;

  // The word shifts left one nibble per byte, so the top nibble is always current.
  always_comb begin
    cur_char = hex_ascii(word_q[31:28]);
`ifdef USB_TX_CRLF_EN
    if (idx_q == 4'd8)      cur_char = ASCII_CR;
    else if (idx_q == 4'd9) cur_char = ASCII_LF;
`endif
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_rdata;
          idx_d    = 4'd0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = cur_char;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_s_q) begin
          cnt_d   = STROBE_LOAD;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // Fixed-width pulse; done_s is deliberately ignored here.
        if (cnt_q == 2'd0) begin
          cnt_d   = RELEASE_LOAD;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (done_s_q) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          word_d  = {word_q[27:0], 4'h0};
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    enable_d = (state_d == ST_STROBE);
  end

  always_ff @(posedge clk_16mhz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      enable_q    <= 1'b0;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      enable_q    <= enable_d;
      done_meta_q <= usb_tx_done;
      done_s_q    <= done_meta_q;
    end
  end

endmodule
